// File: rtl/sa_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_params_pkg
// Description : Shared AXI parameters, encodings and state types for the
//               systolic-array DMA read path.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_params_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } rd_state_e;

    // AXI ARSIZE encoding for a bus of the given data width (bits)
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_burst_master
// Description : Takes one burst request at a time, issues it as an AXI4 INCR
//               read, counts the R beats and forwards them unbuffered to the
//               downstream tile buffer. Flags RRESP/RLAST protocol errors and
//               pulses done after the final burst of a command.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_burst_master
    import sa_params_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    // burst request stream
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic              req_last,
    // AXI AR channel
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    // AXI R channel
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    // downstream beat stream
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    // status
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);

    localparam logic [2:0] c_ARSIZE = axi_size(DATA_W);

    rd_state_e         r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [7:0]        r_len_q;
    logic              r_last_q;
    logic [7:0]        r_beat_cnt;
    logic              r_req_ready;
    logic              r_arvalid;
    logic              r_done;
    logic              r_err;

    logic w_in_r;
    logic w_beat;
    logic w_final;
    logic w_err_evt;

    // Beat qualification; termination is decided by the beat counter alone,
    // RLAST from the slave is only checked against it.
    assign w_in_r    = (r_state == R);
    assign w_beat    = w_in_r && m_axi_rvalid && dout_ready;
    assign w_final   = (r_beat_cnt == r_len_q);
    assign w_err_evt = w_beat && ((m_axi_rresp != AXI_RESP_OKAY) ||
                                  (w_final && !m_axi_rlast)        ||
                                  (!w_final && m_axi_rlast));

    // Burst sequencing FSM: IDLE accepts a request, AR holds the address
    // until handshake, R counts beats until the latched length is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_last_q    <= 1'b0;
            r_beat_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_addr_q    <= req_addr;
                        r_len_q     <= req_len;
                        r_last_q    <= req_last;
                        r_req_ready <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_state     <= AR;
                    end
                end
                AR: begin
                    if (m_axi_arready) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= R;
                    end
                end
                R: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_final) begin
                            r_state     <= IDLE;
                            r_req_ready <= 1'b1;
                            r_done      <= r_last_q;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign req_ready     = r_req_ready;
    assign m_axi_araddr  = r_addr_q;
    assign m_axi_arlen   = r_len_q;
    assign m_axi_arsize  = c_ARSIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = r_arvalid;

    // Zero-latency pass-through; the downstream FIFO provides buffering.
    assign dout_data     = m_axi_rdata;
    assign dout_valid    = w_in_r && m_axi_rvalid;
    assign m_axi_rready  = w_in_r && dout_ready;
    assign dout_last     = w_in_r && w_final && r_last_q;

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire
